pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
// - Owns the fetch program counter of the 5-stage MIPS pipeline and decides its next value every cycle.
// - Arbitrates the redirect sources: exception, EX-stage branch, ID-stage jump, ERET and sequential PC+4.
// - Honours hazard-unit stalls and instruction-memory backpressure, and buffers a redirect that arrives while the PC is held.
// - Runs a small exception-entry FSM and drives the IF/ID flush strobes.
// PARAMETERS
// - PC_W         32            PC and target width
// - RESET_VECTOR 32'h00000000  first fetch address after reset
// - EXC_VECTOR   32'h00000080  exception handler entry address
// PORTS
// - clk           in   1     rising-edge clock
// - Reset         in   1     asynchronous, active-high reset
// - hold_i        in   1     hazard-unit stall; 1 = PC must not advance
// - imem_ready_i  in   1     instruction memory accepts the fetch at pc_o this cycle
// - br_taken_i    in   1     EX stage resolved a taken branch
// - br_target_i   in   PC_W  branch target
// - jump_i        in   1     ID stage decoded J/JAL/JR
// - jump_target_i in   PC_W  jump target
// - exc_i         in   1     exception raised (single-cycle pulse)
// - exc_pc_i      in   PC_W  PC of the faulting instruction
// - eret_i        in   1     return from exception
// - pc_o          out  PC_W  current fetch address
// - fetch_valid_o out  1     pc_o is a real fetch request
// - flush_if_o    out  1     squash the IF/ID register
// - flush_id_o    out  1     squash the ID/EX register
// - epc_o         out  PC_W  saved exception PC
// - state_o       out  2     FSM state, for debug
// BEHAVIOUR
// - Reset (async): pc_o=RESET_VECTOR, epc_o=0, state=BOOT, fetch_valid_o=0, flushes=0, pending redirect cleared.
// - FSM states: BOOT=0, RUN=1, EXC=2.
//   - BOOT -> RUN after exactly one clk following Reset deassertion.
//   - RUN -> EXC on exc_i.
//   - EXC -> RUN after one cycle, with pc_o=EXC_VECTOR.
// - fetch_valid_o = (state==RUN).
// - Advance condition: adv = RUN & ~hold_i & imem_ready_i. The PC register changes only on adv, or on exception entry, or when leaving EXC.
// - Priority, highest first:
//   1. exc_i
//   2. eret_i
//   3. br_taken_i
//   4. jump_i
//   5. pending redirect
//   6. PC+4
// - If a branch and a jump are both asserted, the branch wins and the jump is discarded (the jump is on a younger, squashed instruction).
// - exc_i overrides hold_i and imem_ready_i:
//   - epc_o <= exc_pc_i;
//   - flush_if_o=flush_id_o=1 in the same cycle;
//   - pending redirect is cleared;
//   - state -> EXC.
//   In EXC: fetch_valid_o=0; pc_o <= EXC_VECTOR on exit.
// - eret_i (RUN, adv): pc_o <= epc_o; flush_if_o=1.
// - Taken branch: flush_if_o=flush_id_o=1 in the cycle br_taken_i is sampled, independent of adv. Jump: flush_if_o=1 only.
// - Redirect while not adv (hold_i=1 or imem_ready_i=0):
//   - target is stored in a pending register, with pending valid=1;
//   - a later, higher-priority redirect overwrites it; a lower-priority one is ignored;
//   - on the next adv, pc_o <= pending target and pending is cleared; PC+4 is not applied that cycle.
// - Flush strobes are combinational decodes of the accepted event; they are 0 otherwise and 0 during BOOT.
// - Arithmetic:
//   - PC+4 is modulo 2^PC_W, so 32'hFFFFFFFC wraps to 0;
//   - bits [1:0] of all targets are forced to 0 when loaded;
//   - EXC_VECTOR and RESET_VECTOR are used as given.
// - Reset mid-operation returns to the reset state immediately and discards pending, EXC and epc.
// - Inputs other than exc_i are ignored in BOOT and EXC.
// STRUCTURE
// - Shared package mips_pkg holds:
//   - pcseq_state_t enum (BOOT/RUN/EXC);
//   - default RESET_VECTOR and EXC_VECTOR;
//   - redirect priority codes (REDIR_NONE/JUMP/BR/ERET/EXC).
// - One sub-module, pc_redirect_arb: combinational priority encoder over the requests plus pending. It returns sel_code, target and the flush strobes.
// - Top level holds the PC, epc and pending registers and the FSM.
// - pc_o replaces the standalone PC register; hold_i connects directly to the hazard unit's holdPC.
// TESTING
// - Reset, then release -> cycle 1: pc_o=0, fetch_valid_o=0; then 0, 4, 8, 0xC on successive cycles with imem_ready_i=1.
// - br_taken_i=1 with target 0x100 at pc_o=0x10 -> next pc_o=0x100; flush_if_o=flush_id_o=1 in that cycle.
// - br_taken_i (target 0x200) and jump_i (target 0x300) in the same cycle -> pc_o=0x200; only the branch flushes are asserted.
// - hold_i=1 for 3 cycles, jump to 0x40 on the 2nd held cycle -> pc_o frozen; after release pc_o=0x40, then 0x44.
// - exc_i with exc_pc_i=0x24 while hold_i=1 -> epc_o=0x24, state EXC for 1 cycle, fetch_valid_o=0, then pc_o=0x80. A later eret_i -> pc_o=0x24.
// - pc_o=0xFFFFFFFC advancing -> pc_o=0x00000000. Reset asserted in EXC -> pc_o=0, state_o=BOOT, epc_o=0 asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS fetch PC sequencer
package mips_pkg;
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, EXC = 2'd2} pcseq_state_t;
   typedef logic [2:0] redir_t;
   localparam redir_t REDIR_NONE = 3'd0;
   localparam redir_t REDIR_JUMP = 3'd1;
   localparam redir_t REDIR_BR   = 3'd2;
   localparam redir_t REDIR_ERET = 3'd3;
   localparam redir_t REDIR_EXC  = 3'd4;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: priority encoder over redirect requests and the pending redirect
module pc_redirect_arb
   import mips_pkg::*;
#(
   parameter int              PC_W       = 32,
   parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(DEF_EXC_VECTOR)
)(
   input  logic            i_run,
   input  logic            i_exc_en,
   input  logic            i_exc,
   input  logic            i_eret,
   input  logic [PC_W-1:0] i_epc,
   input  logic            i_br,
   input  logic [PC_W-1:0] i_br_target,
   input  logic            i_jump,
   input  logic [PC_W-1:0] i_jump_target,
   input  logic            i_pend_v,
   input  redir_t          i_pend_code,
   input  logic [PC_W-1:0] i_pend_target,
   output redir_t          o_req_code,
   output redir_t          o_sel_code,
   output logic [PC_W-1:0] o_target,
   output logic            o_flush_if,
   output logic            o_flush_id
);
   logic            w_exc, w_eret, w_br, w_jump;
   logic [PC_W-1:0] w_masked;
   always_comb begin
      w_exc      = i_exc_en & i_exc;
      w_eret     = i_run & i_eret;
      w_br       = i_run & i_br;
      w_jump     = i_run & i_jump;
      o_req_code = w_exc ? REDIR_EXC : w_eret ? REDIR_ERET : w_br ? REDIR_BR : w_jump ? REDIR_JUMP : REDIR_NONE;
      w_masked   = (w_eret ? i_epc : w_br ? i_br_target : i_jump_target) & ~PC_W'(3);
      o_sel_code = o_req_code != REDIR_NONE ? o_req_code : i_pend_v ? i_pend_code : REDIR_NONE;
      o_target   = w_exc ? EXC_VECTOR : o_req_code != REDIR_NONE ? w_masked : i_pend_target;
      o_flush_if = w_exc | w_eret | w_br | w_jump;
      o_flush_id = w_exc | w_br;
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register, redirect buffering and exception-entry FSM
module pc_sequencer
   import mips_pkg::*;
#(
   parameter int              PC_W         = 32,
   parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEF_RESET_VECTOR),
   parameter logic [PC_W-1:0] EXC_VECTOR   = PC_W'(DEF_EXC_VECTOR)
)(
   input  logic            clk,
   input  logic            Reset,
   input  logic            hold_i,
   input  logic            imem_ready_i,
   input  logic            br_taken_i,
   input  logic [PC_W-1:0] br_target_i,
   input  logic            jump_i,
   input  logic [PC_W-1:0] jump_target_i,
   input  logic            exc_i,
   input  logic [PC_W-1:0] exc_pc_i,
   input  logic            eret_i,
   output logic [PC_W-1:0] pc_o,
   output logic            fetch_valid_o,
   output logic            flush_if_o,
   output logic            flush_id_o,
   output logic [PC_W-1:0] epc_o,
   output logic [1:0]      state_o
);
   pcseq_state_t    r_state, w_state_nxt;
   logic [PC_W-1:0] r_pc, r_epc, r_pend_target, w_target;
   logic            r_pend_v, w_run, w_adv, w_exc;
   redir_t          r_pend_code, w_req_code, w_sel_code;
   pc_redirect_arb #(.PC_W(PC_W), .EXC_VECTOR(EXC_VECTOR)) u_arb (
      .i_run         (w_run),
      .i_exc_en      (r_state != BOOT),
      .i_exc         (exc_i),
      .i_eret        (eret_i),
      .i_epc         (r_epc),
      .i_br          (br_taken_i),
      .i_br_target   (br_target_i),
      .i_jump        (jump_i),
      .i_jump_target (jump_target_i),
      .i_pend_v      (r_pend_v),
      .i_pend_code   (r_pend_code),
      .i_pend_target (r_pend_target),
      .o_req_code    (w_req_code),
      .o_sel_code    (w_sel_code),
      .o_target      (w_target),
      .o_flush_if    (flush_if_o),
      .o_flush_id    (flush_id_o)
   );
   always_ff @(posedge clk or posedge Reset)
      if (Reset) r_state <= BOOT;
      else       r_state <= w_state_nxt;
   always_comb begin
      w_run         = r_state == RUN;
      w_adv         = w_run & ~hold_i & imem_ready_i;
      w_exc         = exc_i & (r_state != BOOT);
      w_state_nxt   = w_exc ? EXC : (r_state == RUN) ? RUN : RUN;
      fetch_valid_o = w_run;
   end
   // A redirect seen while the PC is held waits in the pending register; only a stronger one replaces it
   always_ff @(posedge clk or posedge Reset)
      if (Reset) begin
         r_pc          <= RESET_VECTOR;
         r_epc         <= '0;
         r_pend_v      <= 1'b0;
         r_pend_code   <= REDIR_NONE;
         r_pend_target <= '0;
      end else if (w_exc) begin
         r_pc     <= EXC_VECTOR;
         r_epc    <= exc_pc_i;
         r_pend_v <= 1'b0;
      end else if (r_state == EXC) begin
         r_pc <= EXC_VECTOR;
      end else if (w_adv) begin
         r_pc     <= (w_sel_code == REDIR_NONE) ? r_pc + PC_W'(4) : w_target;
         r_pend_v <= 1'b0;
      end else if (w_run && w_req_code != REDIR_NONE && (!r_pend_v || w_req_code > r_pend_code)) begin
         r_pend_v      <= 1'b1;
         r_pend_code   <= w_req_code;
         r_pend_target <= w_target;
      end
   assign pc_o    = r_pc;
   assign epc_o   = r_epc;
   assign state_o = r_state;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  typedef struct {
    string       nm;
    int          cyc;
    logic [31:0] pc;
    logic        fv, fi, fd;
    logic [31:0] epc;
    logic [1:0]  st;
  } exp_t;
  logic        clk = 0, Reset = 1;
  logic        hold_i = 0, imem_ready_i = 0, br_taken_i = 0, jump_i = 0, exc_i = 0, eret_i = 0;
  logic [31:0] br_target_i = 0, jump_target_i = 0, exc_pc_i = 0;
  logic [31:0] pc_o, epc_o;
  logic        fetch_valid_o, flush_if_o, flush_id_o;
  logic [1:0]  state_o;
  int          cyc = 0, checks = 0, passed = 0;
  exp_t        q[$];
  pc_sequencer dut (
    .clk           (clk),
    .Reset         (Reset),
    .hold_i        (hold_i),
    .imem_ready_i  (imem_ready_i),
    .br_taken_i    (br_taken_i),
    .br_target_i   (br_target_i),
    .jump_i        (jump_i),
    .jump_target_i (jump_target_i),
    .exc_i         (exc_i),
    .exc_pc_i      (exc_pc_i),
    .eret_i        (eret_i),
    .pc_o          (pc_o),
    .fetch_valid_o (fetch_valid_o),
    .flush_if_o    (flush_if_o),
    .flush_id_o    (flush_id_o),
    .epc_o         (epc_o),
    .state_o       (state_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic drive(input logic h, rdy, b, input logic [31:0] bt, input logic j,
                       input logic [31:0] jt, input logic e, input logic [31:0] ep, input logic er);
    hold_i = h; imem_ready_i = rdy; br_taken_i = b; br_target_i = bt;
    jump_i = j; jump_target_i = jt; exc_i = e; exc_pc_i = ep; eret_i = er;
  endtask
  task automatic expect_out(input string nm, input logic [31:0] pc, input logic fv, fi, fd,
                            input logic [31:0] epc, input logic [1:0] st);
    exp_t x;
    x.nm = nm; x.cyc = cyc; x.pc = pc; x.fv = fv; x.fi = fi; x.fd = fd; x.epc = epc; x.st = st;
    q.push_back(x);
  endtask
  task automatic step(input string nm, input logic h, rdy, b, input logic [31:0] bt, input logic j,
                      input logic [31:0] jt, input logic e, input logic [31:0] ep, input logic er,
                      input logic [31:0] xpc, input logic xfv, xfi, xfd, input logic [31:0] xepc,
                      input logic [1:0] xst);
    drive(h, rdy, b, bt, j, jt, e, ep, er);
    expect_out(nm, xpc, xfv, xfi, xfd, xepc, xst);
    @(negedge clk);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (pc_o === e.pc && fetch_valid_o === e.fv && flush_if_o === e.fi && flush_id_o === e.fd &&
            epc_o === e.epc && state_o === e.st)
          passed++;
        else
          $display("FAIL %s: got pc=%h fv=%b fi=%b fd=%b epc=%h st=%0d, exp pc=%h fv=%b fi=%b fd=%b epc=%h st=%0d",
                   e.nm, pc_o, fetch_valid_o, flush_if_o, flush_id_o, epc_o, state_o,
                   e.pc, e.fv, e.fi, e.fd, e.epc, e.st);
      end
    end
  end
  initial begin
    @(negedge clk);
    expect_out("in_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    Reset = 0;
    step("boot",        0, 1, 0, 0,            0, 0,       0, 0,     0,  0,            0, 0, 0, 0,     0);
    step("run0",        0, 1, 0, 0,            0, 0,       0, 0,     0,  0,            1, 0, 0, 0,     1);
    step("seq4",        0, 1, 0, 0,            0, 0,       0, 0,     0,  'h4,          1, 0, 0, 0,     1);
    step("seq8",        0, 1, 0, 0,            0, 0,       0, 0,     0,  'h8,          1, 0, 0, 0,     1);
    step("seqC",        0, 1, 0, 0,            0, 0,       0, 0,     0,  'hC,          1, 0, 0, 0,     1);
    step("br_flush",    0, 1, 1, 'h100,        0, 0,       0, 0,     0,  'h10,         1, 1, 1, 0,     1);
    step("br_vs_jump",  0, 1, 1, 'h200,        1, 'h300,   0, 0,     0,  'h100,        1, 1, 1, 0,     1);
    step("hold1",       1, 1, 0, 0,            0, 0,       0, 0,     0,  'h200,        1, 0, 0, 0,     1);
    step("hold2_jump",  1, 1, 0, 0,            1, 'h40,    0, 0,     0,  'h200,        1, 1, 0, 0,     1);
    step("hold3",       1, 1, 0, 0,            0, 0,       0, 0,     0,  'h200,        1, 0, 0, 0,     1);
    step("release",     0, 1, 0, 0,            0, 0,       0, 0,     0,  'h200,        1, 0, 0, 0,     1);
    step("pend_taken",  0, 1, 0, 0,            0, 0,       0, 0,     0,  'h40,         1, 0, 0, 0,     1);
    step("after_pend",  0, 1, 0, 0,            0, 0,       0, 0,     0,  'h44,         1, 0, 0, 0,     1);
    step("exc_held",    1, 1, 0, 0,            0, 0,       1, 'h24,  0,  'h48,         1, 1, 1, 0,     1);
    step("in_exc",      0, 1, 0, 0,            0, 0,       0, 0,     0,  'h80,         0, 0, 0, 'h24,  2);
    step("eret",        0, 1, 0, 0,            0, 0,       0, 0,     1,  'h80,         1, 1, 0, 'h24,  1);
    step("eret_pc",     0, 1, 1, 'hFFFFFFFC,   0, 0,       0, 0,     0,  'h24,         1, 1, 1, 'h24,  1);
    step("pc_max",      0, 1, 0, 0,            0, 0,       0, 0,     0,  'hFFFFFFFC,   1, 0, 0, 'h24,  1);
    step("wrap",        0, 1, 0, 0,            0, 0,       0, 0,     0,  0,            1, 0, 0, 'h24,  1);
    step("busy_br",     0, 0, 1, 'h500,        0, 0,       0, 0,     0,  'h4,          1, 1, 1, 'h24,  1);
    step("busy_jump",   0, 0, 0, 0,            1, 'h600,   0, 0,     0,  'h4,          1, 1, 0, 'h24,  1);
    step("busy_rel",    0, 1, 0, 0,            0, 0,       0, 0,     0,  'h4,          1, 0, 0, 'h24,  1);
    step("pend_br",     0, 1, 0, 0,            1, 'h603,   0, 0,     0,  'h500,        1, 1, 0, 'h24,  1);
    step("mask",        0, 1, 0, 0,            0, 0,       1, 'h30,  0,  'h600,        1, 1, 1, 'h24,  1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    #2 Reset = 1;
    #1;
    checks++;
    if (pc_o === 32'h0 && epc_o === 32'h0 && state_o === 2'd0)
      passed++;
    else
      $display("FAIL async_now: got pc=%h epc=%h st=%0d", pc_o, epc_o, state_o);
    expect_out("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    expect_out("rst_hold", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    Reset = 0;
    step("reboot",      0, 1, 0, 0,            0, 0,       0, 0,     0,  0,            0, 0, 0, 0,     0);
    step("rerun",       0, 1, 0, 0,            0, 0,       0, 0,     0,  0,            1, 0, 0, 0,     1);
    step("reseq4",      0, 1, 0, 0,            0, 0,       0, 0,     0,  'h4,          1, 0, 0, 0,     1);
    @(negedge clk);
    #6;
    while (q.size() > 0) begin
      checks++;
      $display("FAIL %s: never compared, expected pc=%h", q[0].nm, q[0].pc);
      void'(q.pop_front());
    end
    if (passed == checks)
      $display("PASS");
    else
      $display("FAIL");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
